// File: rtl/risc_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The checksum trailer is enabled with LOADER_CHECKSUM_EN.
package risc_loader_pkg;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CHK,
    FLUSH,
    DONE,
    ERR
  } load_state_e;

  localparam int DEFAULT_DEPTH = 64;
  localparam int WORD_BYTES    = 4;
  localparam int HDR_BYTES     = 2;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian word from a byte stream; word_valid pulses
// combinationally with the final byte so the caller can register it directly.
module byte_packer
  import risc_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [7:0]              in_byte,
  input  logic                    take,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_valid
);

  localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [BI_W-1:0] byte_idx_reg;
  logic            last_byte;

  assign last_byte  = (byte_idx_reg == BI_W'(WORD_BYTES - 1));
  assign word_valid = take && last_byte;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_idx_reg <= '0;
    end else if (take) begin
      byte_idx_reg <= last_byte ? '0 : byte_idx_reg + BI_W'(1);
    end
  end

  // Lower lanes are held; the top lane comes straight from the incoming byte.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          lane_reg <= '0;
        end else if (take && (byte_idx_reg == BI_W'(gi))) begin
          lane_reg <= in_byte;
        end
      end
      assign word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  assign word[8*WORD_BYTES-1 -: 8] = in_byte;

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a counted program into instruction memory and holds the CPU in reset
// until it is resident. Define LOADER_CHECKSUM_EN for the XOR checksum trailer.
module instr_mem_loader
  import risc_loader_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter int          CNT_W     = 8 * HDR_BYTES,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  load_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic             in_ready_reg;
  logic             mem_we_reg;
  logic [31:0]      mem_addr_reg;
  logic [31:0]      mem_wdata_reg;
  logic             cpu_hold_reg;
  logic             load_done_reg;
  logic             load_err_reg;

  logic             accept;
  logic             rearm;
  logic [CNT_W-1:0] hdr_next;
  logic             last_word;
  logic [31:0]      pk_word;
  logic             pk_valid;

  assign accept    = in_valid && in_ready_reg;
  assign rearm     = start && ((state_reg == DONE) || (state_reg == ERR));
  assign hdr_next  = CNT_W'({in_data, cnt_reg[7:0]});
  assign last_word = (CNT_W'(word_idx_reg) == (cnt_reg - CNT_W'(1)));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (rearm),
    .in_byte    (in_data),
    .take       (accept && (state_reg == DATA)),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  always_ff @(posedge clk) begin
    if (rst || rearm) begin
      csum_reg <= '0;
    end else if (accept && (state_reg != CHK)) begin
      csum_reg <= csum_reg ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CNT_LO;
      cnt_reg       <= '0;
      word_idx_reg  <= '0;
      in_ready_reg  <= 1'b1;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= BASE_ADDR;
      mem_wdata_reg <= '0;
      cpu_hold_reg  <= 1'b1;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (pk_valid) begin
        mem_we_reg    <= 1'b1;
        mem_wdata_reg <= pk_word;
        mem_addr_reg  <= BASE_ADDR + (32'(word_idx_reg) << 2);
        word_idx_reg  <= word_idx_reg + IDX_W'(1);
      end

      case (state_reg)
        CNT_LO: begin
          if (accept) begin
            cnt_reg[7:0] <= in_data;
            state_reg    <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (accept) begin
            cnt_reg <= hdr_next;
            if (hdr_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_reg    <= CHK;
`else
              state_reg    <= FLUSH;
              in_ready_reg <= 1'b0;
`endif
            end else if (hdr_next > CNT_W'(DEPTH)) begin
              state_reg    <= ERR;
              in_ready_reg <= 1'b0;
              load_err_reg <= 1'b1;
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (pk_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_reg    <= CHK;
`else
            state_reg    <= FLUSH;
            in_ready_reg <= 1'b0;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            if (in_data == csum_reg) begin
              state_reg <= FLUSH;
            end else begin
              state_reg    <= ERR;
              load_err_reg <= 1'b1;
            end
          end
        end
`endif
        FLUSH: begin
          // The final write is visible this cycle, so release the CPU only now.
          state_reg     <= DONE;
          load_done_reg <= 1'b1;
          cpu_hold_reg  <= 1'b0;
        end
        DONE, ERR: begin
          if (start) begin
            state_reg     <= CNT_LO;
            cnt_reg       <= '0;
            word_idx_reg  <= '0;
            in_ready_reg  <= 1'b1;
            cpu_hold_reg  <= 1'b1;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_hold  = cpu_hold_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; inputs change and outputs are sampled on
// the falling edge. Checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_acc = 0;
  logic [7:0] run_xor = 8'h00;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DEPTH     (64),
    .CNT_W     (16),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_q.push_back('{cyc, mem_addr, mem_wdata});
      $display("write cyc=%0d addr=%08h data=%08h", cyc, mem_addr, mem_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_xor = 8'h00;
    wr_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_data = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b for 100 cycles, want 1 (byte %02h)", in_ready, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      last_acc = cyc;
      run_xor = run_xor ^ b;
      $display("byte  cyc=%0d data=%02h", cyc, b);
    end
  endtask

  task automatic finish_stream();
`ifdef LOADER_CHECKSUM_EN
    send_byte(run_xor);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %08h want 00000000", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %08h want 00000000", mem_wdata); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_load_done: got %b want 0", load_done); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL rst_load_err: got %b want 0", load_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int a1 = 0;
    int a2 = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i]);
      if (i == 5) a1 = last_acc;
    end
    a2 = last_acc;
    finish_stream();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL b2b_flush_done: got %b want 0", load_done); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL b2b_flush_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_flush_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL b2b_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (wr_q.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d writes want 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      n_cmp++; if (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'h0000_0013)
        begin n_bad++; $display("FAIL b2b_w0: got %08h@%08h want 00000013@00000000", wr_q[0].data, wr_q[0].addr); end
      n_cmp++; if (wr_q[1].addr !== 32'h4 || wr_q[1].data !== 32'h0010_0093)
        begin n_bad++; $display("FAIL b2b_w1: got %08h@%08h want 00100093@00000004", wr_q[1].data, wr_q[1].addr); end
      n_cmp++; if (wr_q[0].cyc != a1) begin n_bad++; $display("FAIL b2b_w0_cycle: got %0d want %0d", wr_q[0].cyc, a1); end
      n_cmp++; if (wr_q[1].cyc != a1 + 4) begin n_bad++; $display("FAIL b2b_rate: got %0d want %0d", wr_q[1].cyc, a1 + 4); end
`ifndef LOADER_CHECKSUM_EN
      n_cmp++; if (cyc != wr_q[1].cyc + 1) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", cyc, wr_q[1].cyc + 1); end
`endif
    end
    if (a2 != a1 + 4) $display("note: last byte accepted at %0d", a2);
  endtask

  task automatic test_header_err();
    do_reset();
    send_byte(8'h41);
    send_byte(8'h00);
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", load_err); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL err_ready: got %b want 0", in_ready); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL err_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL err_done: got %b want 0", load_done); end
    in_data = 8'h13;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL err_no_write: got %0d writes want 0", wr_q.size()); end
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", load_err); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL err_rearm_err: got %b want 0", load_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL err_rearm_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    finish_stream();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL zero_early_done: got %b want 0", load_done); end
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL zero_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL zero_no_write: got %0d writes want 0", wr_q.size()); end
  endtask

  task automatic test_gappy();
    logic [7:0]  s [14] = '{8'h03, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01,
                            8'hF1, 8'hFF, 8'h73, 8'h00, 8'h00, 8'h00};
    logic [31:0] exp_w [3] = '{32'h0050_0113, 32'hFFF1_0193, 32'h0000_0073};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(s[i]);
    end
    finish_stream();
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL gap_done: got %b want 1", load_done); end
    n_cmp++; if (wr_q.size() != 3) begin n_bad++; $display("FAIL gap_count: got %0d writes want 3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].addr !== 32'(4 * i) || wr_q[i].data !== exp_w[i]) begin
        n_bad++;
        $display("FAIL gap_w%0d: got %08h@%08h want %08h@%08h", i, wr_q[i].data, wr_q[i].addr, exp_w[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s [8] = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    logic [7:0] f [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(s[i]);
    do_reset();
    n_cmp++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin n_bad++; $display("FAIL mid_rst_state: got ready=%b hold=%b want 1 1", in_ready, cpu_hold); end
    for (int i = 0; i < 6; i++) send_byte(f[i]);
    finish_stream();
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL mid_done: got %b want 1", load_done); end
    n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL mid_count: got %0d writes want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_cmp++; if (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'hDEAD_BEEF)
        begin n_bad++; $display("FAIL mid_w0: got %08h@%08h want deadbeef@00000000", wr_q[0].data, wr_q[0].addr); end
    end
  endtask

  task automatic test_restart();
    logic [7:0] s [6] = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL restart_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", load_done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b want 1", in_ready); end
    wr_q.delete();
    run_xor = 8'h00;
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    finish_stream();
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL restart_reload_done: got %b want 1", load_done); end
    n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL restart_count: got %0d writes want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_cmp++; if (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'h0000_0093)
        begin n_bad++; $display("FAIL restart_w0: got %08h@%08h want 00000093@00000000", wr_q[0].data, wr_q[0].addr); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] ck, input logic good);
    logic [7:0] s [6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    send_byte(ck);
    @(negedge clk);
    n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL csum_count: got %0d writes want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_cmp++; if (wr_q[0].data !== 32'h1234_5678) begin n_bad++; $display("FAIL csum_w0: got %08h want 12345678", wr_q[0].data); end
    end
    n_cmp++; if (load_done !== good) begin n_bad++; $display("FAIL csum_done: got %b want %b", load_done, good); end
    n_cmp++; if (load_err !== !good) begin n_bad++; $display("FAIL csum_err: got %b want %b", load_err, !good); end
    n_cmp++; if (cpu_hold !== !good) begin n_bad++; $display("FAIL csum_hold: got %b want %b", cpu_hold, !good); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_header_err();
    test_zero_count();
    test_gappy();
    test_reset_mid();
    test_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum(8'h09, 1'b1);
    test_checksum(8'h08, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory. It receives a byte stream from a host or UART-style source and packs the bytes into 32-bit little-endian instruction words.
- It writes each word into the instruction memory's write port at word-aligned byte addresses.
- It holds the CPU in reset until the whole program is resident.
- It replaces file preload for hardware bring-up.

Parameters:
- DEPTH, 64, number of 32-bit words in the target instruction memory.
- CNT_W, 16, width of the word-count header.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  re-arm pulse; honoured only in DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe, single-cycle.
- mem_addr  out  32  byte address, always 4-aligned.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  high while the program is not fully loaded; drives the CPU reset.
- load_done  out  1  program loaded.
- load_err  out  1  header or protocol error, sticky.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0.
  - state=CNT_LO, byte index=0, word index=0.
- Handshake:
  - A byte transfers on a rising edge where in_valid&in_ready.
  - in_ready=1 in CNT_LO, CNT_HI and DATA (and CHK). It is 0 in FLUSH, DONE and ERR.
- Stream format:
  - Count N arrives first: 2 bytes, low byte first.
  - Then N words, 4 bytes each, least-significant byte first.
- CNT_LO: accept byte -> N[7:0]; go to CNT_HI.
- CNT_HI: accept byte -> N[15:8], then:
  - N==0 -> FLUSH.
  - N>DEPTH -> ERR.
  - otherwise -> DATA.
- DATA:
  - Bytes shift into the packer; byte k goes to bits [8k+7:8k].
  - On acceptance of the 4th byte in cycle t, cycle t+1 has mem_we=1 for exactly one cycle, with mem_addr=BASE_ADDR+4*word_idx and mem_wdata=packed word.
  - word_idx increments after each write.
  - in_ready stays 1 during the write cycle, so back-to-back bytes are sustained at 1 byte/cycle.
  - When the Nth word's 4th byte is accepted, go to FLUSH (or to CHK when the optional feature is compiled in).
- FLUSH: lasts one cycle, covering the final mem_we cycle; then go to DONE.
- DONE:
  - load_done=1 and cpu_hold=0, starting the cycle after the last mem_we.
  - The CPU therefore never fetches an unwritten word.
- ERR: load_err=1, cpu_hold=1, in_ready=0.
- DONE or ERR with start=1: go to CNT_LO, clearing the indices, load_done and load_err; cpu_hold returns to 1 the next cycle.
- start in any other state is ignored.
- Precedence:
  - rst overrides start and in_valid.
  - Reset mid-load discards the partial word and the count.
  - Words already written remain in memory; the loader does not clear them.
- in_valid with in_ready=0 is not consumed. Upstream must hold the byte.
- word_idx never exceeds DEPTH-1, because N is range-checked before DATA.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers all header and data bytes.
  - After the last data byte the loader enters CHK and accepts one checksum byte.
  - The sent byte must equal the running XOR. Match -> FLUSH. Mismatch -> ERR.
  - Words already written stay written; cpu_hold remains 1.
  - For N==0 the path is CNT_HI -> CHK.
- Undefined: no CHK state and no checksum byte; the stream ends at the last data byte.

Decomposition:
- Package risc_loader_pkg holds:
  - the state encoding (CNT_LO, CNT_HI, DATA, CHK, FLUSH, DONE, ERR);
  - the default DEPTH;
  - WORD_BYTES=4;
  - the 2-byte header length constant.
- Sub-module byte_packer: a 4-byte little-endian shift/assemble register with a byte counter and a word_valid pulse.
- The top level owns the FSM, the address counter and the write register.

Test Plan:
- Stream 02 00, 13 00 00 00, 93 00 10 00, sent back-to-back -> two mem_we pulses:
  - addr 0x0 with data 0x00000013;
  - addr 0x4 with data 0x00100093.
  - load_done and cpu_hold=0 one cycle after the second write.
- Header 41 00 (N=65 > 64) -> ERR: load_err=1, in_ready=0, no mem_we, cpu_hold=1.
- Header 00 00 -> no writes; load_done=1 two cycles after the CNT_HI byte is accepted.
- in_valid toggled 1-0-1 randomly during a 3-word load -> the same words and addresses as a gap-free run; no byte is dropped or duplicated.
- rst asserted after 6 data bytes of N=2, then a fresh 1-word stream -> the single write lands at addr 0x0 with the new word; no stale bytes appear.
- LOADER_CHECKSUM_EN, stream 01 00 78 56 34 12 + checksum 0x09 -> write of 0x12345678, then DONE.
- LOADER_CHECKSUM_EN, same stream with checksum 0x08 -> ERR after the write.
- After DONE, pulse start -> state CNT_LO with cpu_hold=1; a second load overwrites from BASE_ADDR.
